// File: rtl/uart_telemetry_tx_pkg.sv
// Shared constants and FSM state type for the UART telemetry link.
// The host parser uses the same header/terminator bytes in both directions.
package uart_telemetry_tx_pkg;

  localparam logic [7:0]  CMD_SET_RPM     = 8'h91;
  localparam logic [7:0]  CMD_RETURN      = 8'hFF;
  localparam int unsigned CHN_WIDTH       = 3;
  localparam int unsigned RPM_FIELD_WIDTH = 13;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    CH_H,
    CH_L,
    TAIL
  } tx_state_e;

endpackage

// File: rtl/uart_telemetry_tx_send.sv
// Byte serialiser, UART 8N1, LSB first.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   tx_start   request to send tx_data; accepted only while tx_ready
//   tx_data    byte to send
//   tx_ready   idle, or in the last cycle of a stop bit (back-to-back start)
//   tx_done    high in the last cycle of the stop bit
//   uart_tx    serial line, idle high (registered)
module uart_send #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       uart_tx
);

  localparam int unsigned       BAUD_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST     = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        BIT_LAST_DATA = 4'd8;
  localparam logic [3:0]        BIT_STOP      = 4'd9;

  logic              active;
  logic [3:0]        bit_idx;   // 0 start, 1..8 data, 9 stop
  logic [BAUD_W-1:0] baud_cnt;
  logic [7:0]        shreg;
  logic              bit_end;

  assign bit_end  = active && (baud_cnt == BAUD_LAST);
  assign tx_done  = bit_end && (bit_idx == BIT_STOP);
  // Accepting a new byte in the final stop-bit cycle removes the idle gap
  // between consecutive bytes of a frame.
  assign tx_ready = !active || tx_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      bit_idx  <= '0;
      baud_cnt <= '0;
      shreg    <= '0;
      uart_tx  <= 1'b1;
    end else if (tx_start && tx_ready) begin
      active   <= 1'b1;
      bit_idx  <= '0;
      baud_cnt <= '0;
      shreg    <= tx_data;
      uart_tx  <= 1'b0;
    end else if (bit_end) begin
      baud_cnt <= '0;
      if (bit_idx == BIT_STOP) begin
        active  <= 1'b0;
        uart_tx <= 1'b1;
      end else begin
        bit_idx <= bit_idx + 4'd1;
        if (bit_idx == BIT_LAST_DATA) begin
          uart_tx <= 1'b1;
        end else begin
          uart_tx <= shreg[0];
          shreg   <= {1'b0, shreg[7:1]};
        end
      end
    end else if (active) begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_telemetry_tx.sv
// Telemetry transmitter: keeps the latest RPM per channel, snapshots all
// channels at frame start and sends 0x91, {ch,sat[12:8]}, sat[7:0] per
// channel, then 0xFF over UART 8N1. Frames start periodically or on request.
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   meas_valid_i   one-cycle measurement strobe
//   meas_chn_i     channel of the measurement (>= NUM_CHN ignored)
//   meas_data_i    measured RPM, signed
//   send_req_i     one-cycle request for an immediate frame
//   uart_tx        serial line, idle high
//   busy_o         frame in flight (through the frame_done_o cycle)
//   frame_done_o   one-cycle pulse when the FSM returns to IDLE
module uart_telemetry_tx
  import uart_telemetry_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned NUM_CHN      = 4,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FRAME_PERIOD = 5000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  meas_valid_i,
  input  logic [CHN_WIDTH-1:0]  meas_chn_i,
  input  logic [DATA_WIDTH-1:0] meas_data_i,
  input  logic                  send_req_i,
  output logic                  uart_tx,
  output logic                  busy_o,
  output logic                  frame_done_o
);

  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'((1 << (RPM_FIELD_WIDTH - 1)) - 1);
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = DATA_WIDTH'(-(1 << (RPM_FIELD_WIDTH - 1)));
  localparam logic [CHN_WIDTH-1:0]         LAST_CH = CHN_WIDTH'(NUM_CHN - 1);

  function automatic logic [RPM_FIELD_WIDTH-1:0] saturate(input logic signed [DATA_WIDTH-1:0] v);
    logic [RPM_FIELD_WIDTH-1:0] r;
    if (v > SAT_MAX)      r = SAT_MAX[RPM_FIELD_WIDTH-1:0];
    else if (v < SAT_MIN) r = SAT_MIN[RPM_FIELD_WIDTH-1:0];
    else                  r = v[RPM_FIELD_WIDTH-1:0];
    return r;
  endfunction

  logic signed [DATA_WIDTH-1:0] shadow [NUM_CHN];
  // Sized to the full channel index range so ch can index it directly;
  // entries at and above NUM_CHN stay zero and are never sent.
  logic [RPM_FIELD_WIDTH-1:0]   snap [2**CHN_WIDTH];

  tx_state_e            state, state_next;
  logic [CHN_WIDTH-1:0] ch, ch_next;
  logic                 pending, tick, start_frame, frame_end;
  logic                 tx_start, tx_ready, tx_done;
  logic [7:0]           tx_data;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CHN; i++) begin
      if (rst)
        shadow[i] <= '0;
      else if (meas_valid_i && meas_chn_i == CHN_WIDTH'(i))
        shadow[i] <= meas_data_i;
    end
  end

  generate
    if (FRAME_PERIOD == 0) begin : g_no_period
      assign tick = 1'b0;
    end else begin : g_period
      localparam int unsigned PW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
      localparam logic [PW-1:0] P_LAST = PW'(FRAME_PERIOD - 1);
      logic [PW-1:0] period_cnt;

      always_ff @(posedge clk) begin
        if (rst || period_cnt == P_LAST) period_cnt <= '0;
        else                             period_cnt <= period_cnt + 1'b1;
      end

      assign tick = (period_cnt == P_LAST);
    end
  endgenerate

  // Next byte is selected from the next state so it can be handed to the
  // serialiser in the same cycle the previous byte reports done.
  always_comb begin
    state_next  = state;
    ch_next     = ch;
    start_frame = 1'b0;
    frame_end   = 1'b0;
    tx_data     = '0;

    case (state)
      IDLE: if (pending) begin
        state_next  = HDR;
        ch_next     = '0;
        start_frame = 1'b1;
      end
      HDR:  if (tx_done) begin
        state_next = CH_H;
        ch_next    = '0;
      end
      CH_H: if (tx_done) state_next = CH_L;
      CH_L: if (tx_done) begin
        if (ch == LAST_CH) begin
          state_next = TAIL;
        end else begin
          state_next = CH_H;
          ch_next    = ch + 1'b1;
        end
      end
      TAIL: if (tx_done) begin
        state_next = IDLE;
        frame_end  = 1'b1;
      end
      default: state_next = IDLE;
    endcase

    case (state_next)
      HDR:     tx_data = CMD_SET_RPM;
      CH_H:    tx_data = {ch_next, snap[ch_next][RPM_FIELD_WIDTH-1:8]};
      CH_L:    tx_data = snap[ch_next][7:0];
      TAIL:    tx_data = CMD_RETURN;
      default: tx_data = '0;
    endcase
  end

  // The header is issued from HDR rather than IDLE, which sets the
  // two-cycle request-to-start-bit latency.
  assign tx_start = (state != IDLE) && (state_next != IDLE) && tx_ready;
  assign busy_o   = (state != IDLE) || frame_done_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ch           <= '0;
      pending      <= 1'b0;
      frame_done_o <= 1'b0;
      for (int unsigned i = 0; i < 2**CHN_WIDTH; i++) snap[i] <= '0;
    end else begin
      state        <= state_next;
      ch           <= ch_next;
      pending      <= tick || send_req_i || (pending && !start_frame);
      frame_done_o <= frame_end;
      if (start_frame)
        for (int unsigned i = 0; i < NUM_CHN; i++) snap[i] <= saturate(shadow[i]);
    end
  end

  uart_send #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_send (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .tx_done  (tx_done),
    .uart_tx  (uart_tx)
  );

endmodule

// File: tb/tb_uart_telemetry_tx.sv
module tb_uart_telemetry_tx;

  localparam int CLK_BIT = 4;
  localparam int FP_B    = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, mv_a, sr_a, tx_a, busy_a, done_a;
  logic [2:0]  mc_a;
  logic [15:0] md_a;
  logic        rst_b, mv_b, sr_b, tx_b, busy_b, done_b;
  logic [2:0]  mc_b;
  logic [15:0] md_b;

  uart_telemetry_tx #(.DATA_WIDTH(16), .NUM_CHN(4), .CLKS_PER_BIT(CLK_BIT), .FRAME_PERIOD(0)) dut_a (
    .clk(clk), .rst(rst_a), .meas_valid_i(mv_a), .meas_chn_i(mc_a), .meas_data_i(md_a),
    .send_req_i(sr_a), .uart_tx(tx_a), .busy_o(busy_a), .frame_done_o(done_a));

  uart_telemetry_tx #(.DATA_WIDTH(16), .NUM_CHN(1), .CLKS_PER_BIT(CLK_BIT), .FRAME_PERIOD(FP_B)) dut_b (
    .clk(clk), .rst(rst_b), .meas_valid_i(mv_b), .meas_chn_i(mc_b), .meas_data_i(md_b),
    .send_req_i(sr_b), .uart_tx(tx_b), .busy_o(busy_b), .frame_done_o(done_b));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
  endtask

  // ---------------- behavioural model (timeline per frame) ----------------
  int     nchn [2] = '{4, 1};
  int     fper [2] = '{0, FP_B};
  int     m_sh [2][8];
  int     m_byte [2][18];
  bit     m_act [2];
  bit     m_pend [2];
  bit     m_valid [2];
  int     m_pcnt [2];
  longint m_s [2];      // cycle the frame leaves IDLE
  longint cyc = 0;

  function automatic int sat13(input int v);
    if (v > 4095)  return 4095;
    if (v < -4096) return -4096;
    return v;
  endfunction

  function automatic longint line_len(input int d);
    return longint'((2 * nchn[d] + 2) * 10 * CLK_BIT);
  endfunction

  function automatic int line_bit(input int d, input longint c);
    longint o;
    int bi, bp;
    o  = c - (m_s[d] + 1);
    bi = int'(o / (10 * CLK_BIT));
    bp = int'((o / CLK_BIT) % 10);
    if (bp == 0) return 0;
    if (bp == 9) return 1;
    return (m_byte[d][bi] >> (bp - 1)) & 1;
  endfunction

  always @(negedge clk) begin
    bit     r [2], sv [2], sq [2];
    int     sc [2], sd [2], act [2];
    int     ex, s, L;
    bit     trig, idle;
    r[0] = rst_a; sv[0] = mv_a; sq[0] = sr_a; sc[0] = int'(mc_a); sd[0] = int'($signed(md_a));
    r[1] = rst_b; sv[1] = mv_b; sq[1] = sr_b; sc[1] = int'(mc_b); sd[1] = int'($signed(md_b));
    act[0] = {29'd0, tx_a, busy_a, done_a};
    act[1] = {29'd0, tx_b, busy_b, done_b};
    for (int d = 0; d < 2; d++) begin
      if (m_valid[d]) begin
        L = int'(line_len(d));
        if (!m_act[d] || cyc < m_s[d] || cyc > m_s[d] + L + 1) ex = 4;
        else if (cyc == m_s[d] + L + 1)                        ex = 4 + 2 + 1;
        else if (cyc == m_s[d])                                ex = 4 + 2;
        else                                                   ex = line_bit(d, cyc) * 4 + 2;
        chk(d == 0 ? "outs_a(tx,busy,done)" : "outs_b(tx,busy,done)", act[d], ex);
      end
      if (r[d]) begin
        m_valid[d] = 1; m_act[d] = 0; m_pend[d] = 0; m_pcnt[d] = 0;
        for (int i = 0; i < 8; i++) m_sh[d][i] = 0;
      end else begin
        trig = sq[d];
        if (fper[d] != 0) begin
          if (m_pcnt[d] == fper[d] - 1) begin trig = 1; m_pcnt[d] = 0; end
          else m_pcnt[d]++;
        end
        idle = !m_act[d] || (cyc > m_s[d] + line_len(d));
        if (m_pend[d] && idle) begin
          m_s[d] = cyc + 1; m_act[d] = 1; m_pend[d] = trig;
          m_byte[d][0] = 'h91;
          for (int c = 0; c < nchn[d]; c++) begin
            s = sat13(m_sh[d][c]) & 'h1FFF;
            m_byte[d][1 + 2*c] = (c << 5) | (s >> 8);
            m_byte[d][2 + 2*c] = s & 'hFF;
          end
          m_byte[d][2*nchn[d] + 1] = 'hFF;
        end else begin
          m_pend[d] = m_pend[d] | trig;
        end
        if (sv[d] && sc[d] < nchn[d]) m_sh[d][sc[d]] = sd[d];
      end
    end
    cyc++;
  end

  // ---------------- line decoders ----------------
  int dc [2] = '{-1, -1};
  int dsh [2];
  int cap [2][64];
  int ncap [2];
  int ndone [2];

  always @(negedge clk) begin
    bit ln [2], rr [2], dn [2];
    int k;
    ln[0] = tx_a; rr[0] = rst_a; dn[0] = done_a;
    ln[1] = tx_b; rr[1] = rst_b; dn[1] = done_b;
    for (int d = 0; d < 2; d++) begin
      if (dn[d]) ndone[d]++;
      if (rr[d]) dc[d] = -1;
      else if (dc[d] < 0) begin
        if (!ln[d]) begin dc[d] = 0; dsh[d] = 0; end
      end else begin
        dc[d]++;
        if (dc[d] % CLK_BIT == CLK_BIT / 2) begin
          k = dc[d] / CLK_BIT;
          if (k >= 1 && k <= 8) dsh[d] = dsh[d] | (int'(ln[d]) << (k - 1));
          else if (k == 9) begin
            if (ncap[d] < 64) begin cap[d][ncap[d]] = dsh[d]; ncap[d]++; end
            dc[d] = -1;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int d, input int ch, input int val);
    logic [15:0] v;
    v = 16'(val);
    if (d == 0) begin mv_a = 1; mc_a = 3'(ch); md_a = v; end
    else        begin mv_b = 1; mc_b = 3'(ch); md_b = v; end
    tick();
    mv_a = 0; mv_b = 0;
  endtask

  task automatic req_a();
    sr_a = 1; tick(); sr_a = 0;
  endtask

  task automatic wait_done(input int d, input int budget, input string name);
    int k;
    logic dn;
    k = 0;
    dn = (d == 0) ? done_a : done_b;
    while (!dn && k < budget) begin
      tick(); k++;
      dn = (d == 0) ? done_a : done_b;
    end
    chk(name, int'(dn), 1);
  endtask

  int e1 [10] = '{'h91, 'h01, 'h2C, 'h3F, 'hFB, 'h40, 'h00, 'h6F, 'hFF, 'hFF};
  int e5 [10] = '{'h91, 'h00, 'h64, 'h3F, 'hFB, 'h40, 'h00, 'h6F, 'hFF, 'hFF};
  int sv [3]  = '{-32768, -4096, 4096};
  int eh [3]  = '{'h10, 'h10, 'h0F};
  int el [3]  = '{'h00, 'h00, 'hFF};
  int eb [4]  = '{'h91, 'h00, 'h00, 'hFF};
  longint starts [$];

  initial begin
    logic prev;
    rst_a = 1; rst_b = 1; mv_a = 0; mv_b = 0; sr_a = 0; sr_b = 0;
    mc_a = '0; mc_b = '0; md_a = '0; md_b = '0;
    repeat (3) tick();
    rst_a = 0;
    tick();
    chk("reset_tx", int'(tx_a), 1);
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_done", int'(done_a), 0);

    // basic frame with saturation on ch3
    ncap[0] = 0; ndone[0] = 0;
    wr(0, 0, 300); wr(0, 1, -5); wr(0, 2, 0); wr(0, 3, 5000);
    req_a();
    wait_done(0, 600, "frame1_done");
    tick();
    chk("frame1_nbytes", ncap[0], 10);
    for (int i = 0; i < 10; i++) chk($sformatf("frame1_byte%0d", i), cap[0][i], e1[i]);
    chk("frame1_done_count", ndone[0], 1);

    // saturation corners on ch0
    for (int i = 0; i < 3; i++) begin
      ncap[0] = 0;
      wr(0, 0, sv[i]);
      req_a();
      wait_done(0, 600, "sat_done");
      tick();
      chk($sformatf("sat%0d_hi", i), cap[0][1], eh[i]);
      chk($sformatf("sat%0d_lo", i), cap[0][2], el[i]);
    end

    // repeated requests mid-frame coalesce into one more frame
    ncap[0] = 0; ndone[0] = 0;
    req_a();
    repeat (60) tick(); req_a();
    repeat (100) tick(); req_a();
    repeat (50) tick(); req_a();
    wait_done(0, 600, "coalesce_done1");
    tick();
    chk("restart_busy", int'(busy_a), 1);
    chk("restart_tx_high", int'(tx_a), 1);
    tick();
    chk("restart_start_bit", int'(tx_a), 0);
    wait_done(0, 600, "coalesce_done2");
    repeat (20) tick();
    chk("no_third_frame", int'(busy_a), 0);
    chk("coalesce_done_count", ndone[0], 2);
    chk("coalesce_nbytes", ncap[0], 20);

    // measurement mid-frame goes to the next frame
    ncap[0] = 0;
    req_a();
    repeat (50) tick();
    wr(0, 0, 100);
    wait_done(0, 600, "midmeas_done1");
    tick();
    chk("midmeas_old_hi", cap[0][1], 'h0F);
    chk("midmeas_old_lo", cap[0][2], 'hFF);
    ncap[0] = 0;
    req_a();
    wait_done(0, 600, "midmeas_done2");
    tick();
    chk("midmeas_new_hi", cap[0][1], 'h00);
    chk("midmeas_new_lo", cap[0][2], 'h64);

    // out-of-range channel ignored; write landing on the snapshot cycle
    ncap[0] = 0;
    wr(0, 5, 777);
    req_a();
    wr(0, 2, 7);
    wait_done(0, 600, "ignore_done");
    tick();
    for (int i = 0; i < 10; i++) chk($sformatf("ignore_byte%0d", i), cap[0][i], e5[i]);
    ncap[0] = 0;
    req_a();
    wait_done(0, 600, "snapwrite_done");
    tick();
    chk("snapwrite_hi", cap[0][5], 'h40);
    chk("snapwrite_lo", cap[0][6], 'h07);

    // periodic trigger on the single-channel instance
    rst_b = 0;
    tick();
    wr(1, 0, -5);
    prev = busy_b;
    for (int i = 0; i < 700; i++) begin
      tick();
      if (busy_b && !prev) starts.push_back(longint'(i));
      prev = busy_b;
    end
    chk("periodic_count", int'(starts.size() >= 3), 1);
    for (int i = 1; i < 3; i++)
      chk($sformatf("periodic_interval%0d", i),
          (starts.size() > i) ? int'(starts[i] - starts[i-1]) : -1, FP_B);

    // reset in the middle of a byte
    begin
      int k;
      k = 0;
      while (!busy_b && k < 250) begin tick(); k++; end
      chk("midrst_frame_started", int'(busy_b), 1);
    end
    repeat (30) tick();
    rst_b = 1;
    tick();
    rst_b = 0;
    chk("midrst_tx", int'(tx_b), 1);
    chk("midrst_busy", int'(busy_b), 0);
    ncap[1] = 0;
    wait_done(1, 450, "midrst_next_done");
    tick();
    chk("midrst_nbytes", ncap[1], 4);
    for (int i = 0; i < 4; i++) chk($sformatf("midrst_byte%0d", i), cap[1][i], eb[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_telemetry_tx.md
Name: uart_telemetry_tx

Overview:
- Transmit-side counterpart of the command receiver: serialises measured per-channel motor RPM back to the host over UART 8N1.
- Uses the same byte framing the host already uses for set_rpm, so one parser on the host handles both directions.
- Sits beside the PID/encoder blocks. Collects the latest measurement per channel, snapshots all channels at frame start, and sends a frame periodically or on request.

Parameters:
- DATA_WIDTH, 16, width of measured RPM (signed two's complement)
- NUM_CHN, 4, number of motor channels reported per frame (1..8)
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200)
- FRAME_PERIOD, 5000000, clk cycles between automatic frames; 0 disables the periodic trigger

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- meas_valid_i  in  1  measurement strobe, one cycle
- meas_chn_i  in  3  channel index of the measurement
- meas_data_i  in  DATA_WIDTH  measured RPM, signed
- send_req_i  in  1  one-cycle request for an immediate frame
- uart_tx  out  1  serial line, idle high
- busy_o  out  1  high while a frame is in flight
- frame_done_o  out  1  one-cycle pulse after the last stop bit of a frame

Behaviour:
- Reset: already decided — one clock; reset is synchronous and active-high.
  - Every flop is cleared on a clk edge with rst=1: uart_tx=1, busy_o=0, frame_done_o=0, shadow regs=0, period counter=0, pending=0, FSM=IDLE.
  - rst asserted mid-frame aborts the frame; uart_tx is high from the next edge.
- Capture:
  - meas_valid_i with meas_chn_i < NUM_CHN writes that channel's shadow reg.
  - meas_chn_i >= NUM_CHN is ignored.
  - Capture is independent of FSM state.
- Trigger:
  - Period counter runs 0..FRAME_PERIOD-1 and ticks on wrap.
  - A tick or send_req_i sets pending.
  - If busy, pending holds exactly one deferred frame; further triggers coalesce into it.
  - In IDLE with pending set: clear pending, snapshot all shadow regs, enter HDR.
  - If the snapshot and a meas_valid_i land in the same cycle, the snapshot takes the OLD value; the new value goes into the shadow reg for the next frame.
- Saturation at snapshot:
  - Value is clamped to the 13-bit signed range [-4096, 4095], giving sat[12:0].
- Frame bytes, in order:
  - 0x91 header.
  - For ch = 0..NUM_CHN-1: high byte {ch[2:0], sat[12:8]}, then low byte sat[7:0].
  - 0xFF terminator.
  - Total 2*NUM_CHN+2 bytes.
- FSM: IDLE -> HDR -> CH_H -> CH_L, with CH_L -> CH_H while ch < NUM_CHN-1, otherwise -> TAIL -> IDLE.
  - Each state issues one byte to the serialiser and advances only when the serialiser reports done.
- Byte timing:
  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each exactly CLKS_PER_BIT cycles.
  - Bytes go back to back: next start bit begins the cycle after the stop bit ends, so no idle gap inside a frame.
- Latency: uart_tx falls for the header start bit exactly 2 cycles after the edge on which pending is set with FSM in IDLE.
- Status outputs:
  - busy_o is high from leaving IDLE until the cycle frame_done_o pulses, inclusive.
  - frame_done_o pulses in the cycle the FSM returns to IDLE.
  - A pending request starts the next frame no earlier than the following cycle.

Decomposition:
- Shared package:
  - CMD_SET_RPM = 8'h91, CMD_RETURN = 8'hFF, CHN_WIDTH = 3.
  - RPM_FIELD_WIDTH = 13, and the FSM state enum.
  - The receiver will be updated to use the same constants.
- Sub-module uart_send (byte serialiser, parameter CLKS_PER_BIT):
  - Inputs: tx_start, tx_data[7:0].
  - Outputs: tx_ready, tx_done pulse, uart_tx.
  - Bit counter plus baud counter; a start is accepted only when tx_ready.

Test Plan (CLKS_PER_BIT=4, FRAME_PERIOD=0, NUM_CHN=4):
- After rst, write ch0=300 (0x012C), ch1=-5, ch2=0, ch3=5000; pulse send_req_i.
  - Decoded bytes: 91 01 2C 3F FB 40 00 6F FF FF.
  - Ch3 saturates to 4095.
  - 100 bit times, no gaps, frame_done_o exactly once.
- Saturation: ch0=-32768 -> bytes 10 00. ch0=-4096 -> 10 00. ch0=4096 -> 0F FF.
- Request during frame: send_req_i 3x mid-frame -> exactly one further frame, starting 1 cycle after frame_done_o.
- Measurement during frame: write ch0=100 mid-frame -> current frame carries the old value, next frame carries 00 64.
- meas_chn_i=5 with value 777 -> no shadow change; frame contents identical to the previous frame.
- FRAME_PERIOD=200 -> frames start every 200 cycles. Also assert rst mid-byte -> uart_tx=1 next cycle, busy_o=0, the next frame restarts with header 0x91.
